// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
//   Round-robin scheduler sharing one signed 8x8 Baugh-Wooley / Wallace-tree
//   multiplier between NREQ requesters. It has two register stages:
//   S1 holds the granted operands. S2 holds the product and the requester ID.
//   It sustains one product per cycle unless the response side stalls.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]    per-requester operand valid
//   req_a      [8*NREQ]  packed signed operand A (requester i at [8i+7:8i])
//   req_b      [8*NREQ]  packed signed operand B (same packing)
//   req_ready  [NREQ]    one-hot grant (or zero); accept = valid & ready
//   rsp_valid            product valid
//   rsp_ready            downstream accepts the product
//   rsp_prod   [16]      signed product a*b
//   rsp_id     [IDW]     requester that issued the product
//   op_count   [CNTW]    responses accepted downstream, wraps
module mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_prod,
    output logic [IDW-1:0]      rsp_id,
    output logic [CNTW-1:0]     op_count
);

    logic            s1_valid_reg;
    logic [7:0]      s1_a_reg, s1_b_reg;
    logic [IDW-1:0]  s1_id_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic            rsp_valid_reg;
    logic [15:0]     rsp_prod_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [CNTW-1:0] op_count_reg;

    logic            s2_load, s1_free, rsp_fire, accept;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  rr_ptr_next;
    logic [15:0]     mult_prod;

    assign rsp_fire = rsp_valid_reg & rsp_ready;
    assign s2_load  = s1_valid_reg & (~rsp_valid_reg | rsp_ready);
    assign s1_free  = ~s1_valid_reg | s2_load;

    // First valid requester starting at rr_ptr. The loop runs downward so the
    // lowest offset (highest priority) overwrites the others.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found && s1_free && !rst)
            req_ready[grant_idx] = 1'b1;
    end

    assign accept      = |(req_valid & req_ready);
    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // ------------------------------------------------------------------
    // Baugh-Wooley partial products. A bit is inverted when exactly one of
    // its operand bits is a sign bit. The constant 2^8 + 2^15 completes the
    // two's-complement correction modulo 2^16.
    // ------------------------------------------------------------------
    logic [7:0]  pp_bits [8];
    logic [15:0] pp_row  [9];

    for (genvar gi = 0; gi < 8; gi++) begin : g_pp_row
        for (genvar gj = 0; gj < 8; gj++) begin : g_pp_bit
            if ((gi == 7) != (gj == 7)) begin : g_inv
                assign pp_bits[gi][gj] = ~(s1_a_reg[gj] & s1_b_reg[gi]);
            end else begin : g_pos
                assign pp_bits[gi][gj] = s1_a_reg[gj] & s1_b_reg[gi];
            end
        end
        assign pp_row[gi] = 16'(pp_bits[gi]) << gi;
    end
    assign pp_row[8] = 16'h8100;

    // 3:2 carry-save compressor. It returns {carry, sum}. The carry is
    // already shifted into place, and bits above 15 are dropped (mod 2^16).
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        logic [15:0] s, c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // Wallace reduction of the rows: 9 -> 6 -> 4 -> 3 -> 2, then one adder.
    logic [15:0] l1 [6];
    logic [15:0] l2 [4];
    logic [15:0] l3 [2];
    logic [15:0] l4 [2];

    always_comb begin
        {l1[1], l1[0]} = csa(pp_row[0], pp_row[1], pp_row[2]);
        {l1[3], l1[2]} = csa(pp_row[3], pp_row[4], pp_row[5]);
        {l1[5], l1[4]} = csa(pp_row[6], pp_row[7], pp_row[8]);
        {l2[1], l2[0]} = csa(l1[0], l1[1], l1[2]);
        {l2[3], l2[2]} = csa(l1[3], l1[4], l1[5]);
        {l3[1], l3[0]} = csa(l2[0], l2[1], l2[2]);
        {l4[1], l4[0]} = csa(l3[0], l3[1], l2[3]);
        mult_prod      = l4[0] + l4[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_id_reg     <= '0;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_prod_reg  <= '0;
            rsp_id_reg    <= '0;
            op_count_reg  <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_a_reg     <= req_a[grant_idx*8 +: 8];
                s1_b_reg     <= req_b[grant_idx*8 +: 8];
                s1_id_reg    <= grant_idx;
                rr_ptr_reg   <= rr_ptr_next;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                rsp_valid_reg <= 1'b1;
                rsp_prod_reg  <= mult_prod;
                rsp_id_reg    <= s1_id_reg;
            end else if (rsp_fire) begin
                rsp_valid_reg <= 1'b0;
            end

            if (rsp_fire)
                op_count_reg <= op_count_reg + 1'b1;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler (NREQ=4, CNTW=4).
// The driver issues stimulus and predicts the grants from a queue-level
// pipeline model. It pushes the expected products. The monitor pops an
// expected product whenever the DUT hands over a response.
module tb_mult_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic [CNTW-1:0]   op_count;

    mult_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prod(rsp_prod), .rsp_id(rsp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: the items in flight, the round-robin pointer, and whether
    // the last edge accepted (a fresh item still sits in the operand stage).
    int   m_cnt = 0;
    int   m_ptr = 0;
    bit   m_fresh = 0;
    int   last_grant = -1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock cycle of stimulus. Inputs change just after the rising edge,
    // and the prediction and checks run on the falling edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [31:0] a,
                        input logic [31:0] b, input logic rr, input logic r);
        bit found = 0;
        int g = 0;
        bit free, exp_rv, consume, acc;
        logic [NREQ-1:0] exp_ready;
        @(posedge clk);
        #1;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr; rst = r;
        @(negedge clk);
        if (r) begin
            chk("ready_in_reset", int'(req_ready), 0);
            exp_q.delete();
            m_cnt = 0; m_ptr = 0; m_fresh = 0; last_grant = -1;
            $display("cycle reset");
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            int idx = (m_ptr + k) % NREQ;
            if (!found && v[idx]) begin found = 1; g = idx; end
        end
        // The operand stage can take a new item unless both slots are full and
        // the head cannot leave this edge.
        free      = (m_cnt < 2) || rr;
        exp_ready = (found && free) ? NREQ'(1) << g : '0;
        exp_rv    = (m_cnt == 2) || (m_cnt == 1 && !m_fresh);
        chk("req_ready", int'(req_ready), int'(exp_ready));
        chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
        consume = exp_rv && rr;
        acc     = (exp_ready != 0);
        if (acc) begin
            logic signed [7:0] sa, sb;
            exp_t e;
            sa = a[g*8 +: 8];
            sb = b[g*8 +: 8];
            e.prod = 16'(int'(sa) * int'(sb));
            e.id   = g;
            exp_q.push_back(e);
            if (last_grant == 3 && v[1])
                chk("fair_no_double3", int'(onehot_idx(req_ready) == 3), 0);
            last_grant = g;
            m_ptr = (g + 1) % NREQ;
            $display("cycle v=%b rr=%0d grant=%0d a=%0d b=%0d", v, rr, g, sa, sb);
        end else begin
            $display("cycle v=%b rr=%0d no grant", v, rr);
        end
        m_cnt   = m_cnt - int'(consume) + int'(acc);
        m_fresh = acc;
    endtask

    // Monitor: checks the response side independently of the driver.
    int          pops = 0;
    bit          stall = 0;
    logic [15:0] held_prod;
    int          held_id;

    always @(negedge clk) begin
        if (rst) begin
            pops  = 0;
            stall = 0;
        end else begin
            chk("op_count", int'(op_count), pops % (1 << CNTW));
            if (stall) begin
                chk("stall_valid", int'(rsp_valid), 1);
                chk("stall_prod", int'(rsp_prod), int'(held_prod));
                chk("stall_id", int'(rsp_id), held_id);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_prod", int'(rsp_prod), int'(e.prod));
                    chk("rsp_id", int'(rsp_id), e.id);
                    $display("rsp id=%0d prod=%0d expected id=%0d prod=%0d",
                             rsp_id, $signed(rsp_prod), e.id, $signed(e.prod));
                end
                pops++;
            end
            stall     = rsp_valid && !rsp_ready;
            held_prod = rsp_prod;
            held_id   = int'(rsp_id);
        end
    end

    initial begin
        // Reset
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);

        // Single request from requester 2: 10 * 1
        step(4'b0100, 32'h000A_0000, 32'h0001_0000, 1'b1, 1'b0);
        repeat (3) step('0, '0, '0, 1'b1, 1'b0);

        // All valid: (-1,-1), (127,-1), (-128,1), (-128,-128)
        repeat (8) step(4'b1111, 32'h8080_7FFF, 32'h8001_FFFF, 1'b1, 1'b0);
        repeat (3) step('0, '0, '0, 1'b1, 1'b0);

        // Backpressure: requesters 0 and 1 valid, response stalled for 5 cycles
        repeat (5) step(4'b0011, 32'h0000_0305, 32'h0000_FD07, 1'b0, 1'b0);
        repeat (4) step('0, '0, '0, 1'b1, 1'b0);

        // Fairness: requester 3 always valid, requester 1 toggling
        for (int i = 0; i < 12; i++)
            step((i % 2 == 1) ? 4'b1010 : 4'b1000, $urandom, $urandom, 1'b1, 1'b0);
        repeat (3) step('0, '0, '0, 1'b1, 1'b0);

        // Mid-operation reset with S1 and S2 full, then all requesters valid
        repeat (3) step(4'b1111, $urandom, $urandom, 1'b0, 1'b0);
        step(4'b1111, $urandom, $urandom, 1'b0, 1'b1);
        repeat (6) step(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
        repeat (3) step('0, '0, '0, 1'b1, 1'b0);

        // Randomised traffic with occasional stalls and rare resets
        for (int i = 0; i < 300; i++)
            step(4'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 199) == 0);

        // Drain
        repeat (6) step('0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one signed 8x8 `Wallace_BaughWooley` multiplier instance between NREQ requesters in the accelerator datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, registers the operands, multiplies, and returns a registered 16-bit product tagged with the requester ID. It sustains one product per cycle unless the response side applies backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- CNTW, 16, width of the completed-operation counter

- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, synchronous, active-high reset
- req_valid, in, NREQ, per-requester operand valid
- req_a, in, 8*NREQ, packed signed operand A; requester i uses bits [8i+7:8i]
- req_b, in, 8*NREQ, packed signed operand B; same packing as req_a
- req_ready, out, NREQ, one-hot or zero; the request is accepted when req_valid[i] and req_ready[i] are both high on a clock edge
- rsp_valid, out, 1, product valid
- rsp_ready, in, 1, downstream accepts the product
- rsp_prod, out, 16, signed product a*b
- rsp_id, out, IDW, index of the requester that issued the product
- op_count, out, CNTW, number of responses accepted downstream

## Operation
- The clock and reset are fixed: one clock; reset is synchronous and active-high, on ports `clk` and `rst`.
- Two register stages surround the combinational multiplier:
  - S1 (operand) holds s1_valid, s1_a, s1_b, s1_id.
  - S2 (result) holds rsp_valid, rsp_prod, rsp_id.
- Advance conditions:
  - s2_load = s1_valid & (~rsp_valid | rsp_ready).
  - s1_free = ~s1_valid | s2_load.
- Arbitration is combinational.
  - The grant g is the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready[g] = s1_free. All other req_ready bits are 0.
  - When no requester is valid, req_ready is all zero.
- On accept:
  - S1 loads the operands of requester g, sets s1_id = g and s1_valid = 1.
  - rr_ptr becomes (g+1) mod NREQ.
  - rr_ptr does not change on any cycle without an accept.
- On s2_load: rsp_prod = multiplier(s1_a, s1_b), rsp_id = s1_id, rsp_valid = 1.
- When S1 empties without a new accept, s1_valid clears.
- When rsp_valid & rsp_ready and no s2_load occurs, rsp_valid clears.
- Arithmetic is full two's-complement 8x8->16 with no saturation. -128*-128 = 16384 is representable.
- op_count increments on every rsp_valid & rsp_ready and wraps modulo 2^CNTW.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_prod and rsp_id hold. S1 then holds as well, and req_ready is all zero whenever S1 is full.
- Requests are never dropped or duplicated. Responses return in grant order.
- Reset values:
  - s1_valid=0, rsp_valid=0, rsp_prod=0, rsp_id=0, op_count=0, rr_ptr=0.
  - req_ready follows combinationally and is 0 during reset.
- Reset mid-operation discards S1 and S2 contents. No response is issued for them.

## Timing
- Latency: a request accepted at edge N produces rsp_valid=1 after edge N+1, provided S2 is free. The response can be consumed at edge N+2.
- Throughput: one accept per cycle while rsp_ready=1.
- Backpressure while S2 is full and rsp_ready=0:
  - The first stalled cycle still accepts one request into an empty S1.
  - After that, req_ready=0 until rsp_ready rises.
- Same-edge behaviour: when rsp_ready and req_valid are both high, S2 drains, S1 moves to S2, and S1 accepts a new request on the same edge.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and internal state. Requesters must not make req_valid depend on req_ready.
- rr_ptr wrap-around: after granting requester NREQ-1, requester 0 has highest priority.

## Test plan
- Single request: reset, then requester 2 sends a=10, b=1. Required: accepted on the first edge; rsp_valid one cycle later with rsp_prod=10, rsp_id=2; op_count=1 after consumption.
- All requesters valid every cycle, rsp_ready=1: requester i sends (a,b) = (-1,-1), (127,-1), (-128,1), (-128,-128). Required: grants in order 0,1,2,3,0,... with one per cycle; products 1, -127, -128, 16384.
- Backpressure: requesters 0 and 1 valid, rsp_ready=0 for 5 cycles.
  - Required: exactly two accepts, then req_ready=0.
  - rsp_prod/rsp_id stable while stalled.
  - After rsp_ready=1, both responses are delivered in order and no accepts are lost.
- Round-robin fairness: requester 3 is held valid continuously and requester 1 is toggled valid. Required: requester 3 is never granted twice in a row while requester 1 is pending.
- Mid-operation reset: assert rst for one cycle while S1 and S2 are full. Required: rsp_valid=0, op_count=0, and the next grant goes to requester 0 first.
- Counter wrap: CNTW=4, 17 responses consumed. Required: op_count=1.
